// File: rtl/data_path.sv
// Datapath of the 8-bit CPU: IR/MAR/PC/A/B/CCR registers, Bus1/Bus2 muxes and ALU.
// Optional DP_BUS_CHECK_EN adds a sticky bus_err flag for reserved selector codes.
module data_path #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IR_Load,
    input  logic             MAR_Load,
    input  logic             PC_Load,
    input  logic             PC_Inc,
    input  logic             A_Load,
    input  logic             B_Load,
    input  logic             CCR_Load,
    input  logic [2:0]       ALU_Sel,
    input  logic [1:0]       Bus1_Sel,
    input  logic [1:0]       Bus2_Sel,
    input  logic [WIDTH-1:0] from_memory,
    output logic [WIDTH-1:0] IR,
    output logic [3:0]       CCR_Result,
    output logic [WIDTH-1:0] address,
`ifdef DP_BUS_CHECK_EN
    output logic             bus_err,
`endif
    output logic [WIDTH-1:0] to_memory
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_INC = 3'b100,
        ALU_DEC = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        B1_PC = 2'b00,
        B1_A  = 2'b01,
        B1_B  = 2'b10,
        B1_RS = 2'b11
    } bus1_sel_e;

    typedef enum logic [1:0] {
        B2_ALU = 2'b00,
        B2_B1  = 2'b01,
        B2_MEM = 2'b10,
        B2_RS  = 2'b11
    } bus2_sel_e;

    logic [WIDTH-1:0] pc, a_reg, b_reg;
    logic [WIDTH-1:0] bus1, bus2;
    logic [WIDTH-1:0] in1, in2, addend, alu_res;
    logic [WIDTH:0]   add_w, sub_w;
    logic             flag_n, flag_z, flag_v, flag_c;

    always_comb begin
        bus1 = pc;
        unique case (bus1_sel_e'(Bus1_Sel))
            B1_A:    bus1 = a_reg;
            B1_B:    bus1 = b_reg;
            default: bus1 = pc;
        endcase
    end

    always_comb begin
        bus2 = alu_res;
        unique case (bus2_sel_e'(Bus2_Sel))
            B2_B1:   bus2 = bus1;
            B2_MEM:  bus2 = from_memory;
            default: bus2 = alu_res;
        endcase
    end

    assign to_memory = bus1;

    // In2 swaps to A when Bus1 carries B, so SUB with Bus1=B yields B-A.
    assign in1    = bus1;
    assign in2    = (bus1_sel_e'(Bus1_Sel) == B1_B) ? a_reg : b_reg;
    assign addend = (alu_op_e'(ALU_Sel) == ALU_INC || alu_op_e'(ALU_Sel) == ALU_DEC)
                    ? WIDTH'(1) : in2;
    assign add_w  = {1'b0, in1} + {1'b0, addend};
    assign sub_w  = {1'b0, in1} - {1'b0, addend};

    always_comb begin
        alu_res = '0;
        flag_v  = 1'b0;
        flag_c  = 1'b0;
        unique case (alu_op_e'(ALU_Sel))
            ALU_ADD, ALU_INC: begin
                alu_res = add_w[WIDTH-1:0];
                flag_c  = add_w[WIDTH];
                flag_v  = (in1[WIDTH-1] == addend[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SUB, ALU_DEC: begin
                alu_res = sub_w[WIDTH-1:0];
                flag_c  = sub_w[WIDTH];
                flag_v  = (in1[WIDTH-1] != addend[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_AND: alu_res = in1 & in2;
            ALU_OR:  alu_res = in1 | in2;
            ALU_XOR: alu_res = in1 ^ in2;
            ALU_NOT: alu_res = ~in1;
            default: alu_res = '0;
        endcase
    end

    assign flag_n = alu_res[WIDTH-1];
    assign flag_z = (alu_res == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IR         <= '0;
            address    <= '0;
            pc         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            CCR_Result <= '0;
        end else begin
            if (IR_Load)  IR      <= bus2;
            if (MAR_Load) address <= bus2;
            if (PC_Load)
                pc <= bus2;
            else if (PC_Inc)
                pc <= pc + WIDTH'(1);
            if (A_Load)   a_reg   <= bus2;
            if (B_Load)   b_reg   <= bus2;
            if (CCR_Load) CCR_Result <= {flag_n, flag_z, flag_v, flag_c};
        end
    end

`ifdef DP_BUS_CHECK_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            bus_err <= 1'b0;
        else if (Bus1_Sel == 2'b11 || Bus2_Sel == 2'b11)
            bus_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: ALU vector table plus hand-written
// register-transfer sequences (reset, fetch, PC wrap, multi-load, bus_err).
module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       IR_Load = 1'b0, MAR_Load = 1'b0, PC_Load = 1'b0, PC_Inc = 1'b0;
    logic       A_Load = 1'b0, B_Load = 1'b0, CCR_Load = 1'b0;
    logic [2:0] ALU_Sel = '0;
    logic [1:0] Bus1_Sel = '0, Bus2_Sel = '0;
    logic [7:0] from_memory = '0;
    logic [7:0] IR, address, to_memory;
    logic [3:0] CCR_Result;
`ifdef DP_BUS_CHECK_EN
    logic       bus_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    data_path #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .from_memory(from_memory), .IR(IR), .CCR_Result(CCR_Result),
        .address(address),
`ifdef DP_BUS_CHECK_EN
        .bus_err(bus_err),
`endif
        .to_memory(to_memory)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] alu;
        logic [1:0] sel1;
        logic [7:0] exp_res;
        logic [3:0] exp_ccr;
    } alu_vec_t;

    alu_vec_t vecs [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for the active edge, settle, then drop all load strobes.
    task automatic tick();
        @(posedge Clk);
        #1;
        IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0;
        A_Load = 0; B_Load = 0; CCR_Load = 0;
    endtask

    task automatic load_a(input logic [7:0] v);
        Bus2_Sel = 2'b10; from_memory = v; A_Load = 1; tick();
    endtask

    task automatic load_b(input logic [7:0] v);
        Bus2_Sel = 2'b10; from_memory = v; B_Load = 1; tick();
    endtask

    task automatic pulse_reset();
        #3 Reset = 0;
        #2 Reset = 1;
    endtask

    initial begin
        vecs[0]  = '{8'h7F, 8'h01, 3'b000, 2'b01, 8'h80, 4'b1010};
        vecs[1]  = '{8'hFF, 8'h01, 3'b000, 2'b01, 8'h00, 4'b0101};
        vecs[2]  = '{8'h05, 8'h03, 3'b001, 2'b10, 8'hFE, 4'b1001};
        vecs[3]  = '{8'hF0, 8'h0F, 3'b010, 2'b10, 8'h00, 4'b0100};
        vecs[4]  = '{8'h80, 8'h01, 3'b001, 2'b01, 8'h7F, 4'b0010};
        vecs[5]  = '{8'hA0, 8'h05, 3'b011, 2'b01, 8'hA5, 4'b1000};
        vecs[6]  = '{8'h7F, 8'h33, 3'b100, 2'b01, 8'h80, 4'b1010};
        vecs[7]  = '{8'hFF, 8'h33, 3'b100, 2'b01, 8'h00, 4'b0101};
        vecs[8]  = '{8'h00, 8'h33, 3'b101, 2'b01, 8'hFF, 4'b1001};
        vecs[9]  = '{8'h80, 8'h33, 3'b101, 2'b01, 8'h7F, 4'b0010};
        vecs[10] = '{8'hFF, 8'h0F, 3'b110, 2'b01, 8'hF0, 4'b1000};
        vecs[11] = '{8'h00, 8'h77, 3'b111, 2'b01, 8'hFF, 4'b1000};
        vecs[12] = '{8'h00, 8'h5A, 3'b111, 2'b10, 8'hA5, 4'b1000};
        vecs[13] = '{8'h80, 8'h80, 3'b000, 2'b01, 8'h00, 4'b0111};
        vecs[14] = '{8'h05, 8'h05, 3'b001, 2'b01, 8'h00, 4'b0100};

        // Reset state
        #12 Reset = 1;
        #1;
        chk("rst_ir", IR, 8'h00);
        chk("rst_addr", address, 8'h00);
        chk("rst_ccr", {4'h0, CCR_Result}, 8'h00);
        chk("rst_pc", to_memory, 8'h00);
`ifdef DP_BUS_CHECK_EN
        chk("rst_bus_err", {7'h0, bus_err}, 8'h00);
`endif

        // Asynchronous reset mid-cycle with A loaded
        @(posedge Clk); #1;
        load_a(8'h55);
        Bus1_Sel = 2'b01; #1;
        chk("a_loaded", to_memory, 8'h55);
        #2 Reset = 0;
        #1;
        chk("async_rst_a", to_memory, 8'h00);
        chk("async_rst_addr", address, 8'h00);
        chk("async_rst_ccr", {4'h0, CCR_Result}, 8'h00);
        #1 Reset = 1;
        Bus1_Sel = 2'b00;
        PC_Inc = 1; tick();
        PC_Inc = 1; tick();
        PC_Inc = 1; tick();
        chk("pc_inc3", to_memory, 8'h03);
        chk("pc_inc3_addr", address, 8'h00);
        Bus1_Sel = 2'b11; #1;
        chk("bus1_11_is_pc", to_memory, 8'h03);
        Bus1_Sel = 2'b00;

        // Fetch sequence from PC=0
        pulse_reset();
        @(posedge Clk); #1;
        Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1; tick();
        PC_Inc = 1; tick();
        Bus2_Sel = 2'b10; from_memory = 8'h86; IR_Load = 1; tick();
        chk("fetch_addr", address, 8'h00);
        chk("fetch_pc", to_memory, 8'h01);
        chk("fetch_ir", IR, 8'h86);
`ifdef DP_BUS_CHECK_EN
        chk("bus_err_clean", {7'h0, bus_err}, 8'h00);
`endif

        // ALU vector table; result lands in MAR, flags in CCR
        foreach (vecs[i]) begin
            load_a(vecs[i].a);
            load_b(vecs[i].b);
            ALU_Sel = vecs[i].alu; Bus1_Sel = vecs[i].sel1; Bus2_Sel = 2'b00;
            MAR_Load = 1; CCR_Load = 1; tick();
            chk($sformatf("alu%0d_res", i), address, vecs[i].exp_res);
            chk($sformatf("alu%0d_ccr", i), {4'h0, CCR_Result}, {4'h0, vecs[i].exp_ccr});
        end

        // CCR holds without CCR_Load (last vector left 0100)
        load_a(8'hFF); load_b(8'h01);
        ALU_Sel = 3'b000; Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; A_Load = 1; tick();
        chk("ccr_hold", {4'h0, CCR_Result}, 8'h04);
        chk("add_into_a", to_memory, 8'h00);

        // SUB with Bus1=B into B, then AND
        load_a(8'h05); load_b(8'h03);
        ALU_Sel = 3'b001; Bus1_Sel = 2'b10; Bus2_Sel = 2'b00; B_Load = 1; CCR_Load = 1; tick();
        chk("sub_ba_b", to_memory, 8'hFE);
        chk("sub_ba_ccr", {4'h0, CCR_Result}, 8'h09);

        // Several loads take the same Bus2 value
        Bus2_Sel = 2'b10; from_memory = 8'h3C;
        A_Load = 1; B_Load = 1; MAR_Load = 1; IR_Load = 1; tick();
        chk("multi_ir", IR, 8'h3C);
        chk("multi_addr", address, 8'h3C);
        Bus1_Sel = 2'b01; #1; chk("multi_a", to_memory, 8'h3C);
        Bus1_Sel = 2'b10; #1; chk("multi_b", to_memory, 8'h3C);

        // Self-load via Bus1 keeps the old value
        Bus1_Sel = 2'b01; Bus2_Sel = 2'b01; from_memory = 8'hEE; A_Load = 1; tick();
        chk("self_load_a", to_memory, 8'h3C);

        // PC wrap and PC_Load priority over PC_Inc
        Bus1_Sel = 2'b00;
        Bus2_Sel = 2'b10; from_memory = 8'hFF; PC_Load = 1; tick();
        chk("pc_ff", to_memory, 8'hFF);
        PC_Inc = 1; tick();
        chk("pc_wrap", to_memory, 8'h00);
        from_memory = 8'h40; PC_Load = 1; PC_Inc = 1; tick();
        chk("pc_load_wins", to_memory, 8'h40);

        // Bus2_Sel=11 decodes as ALU result
        load_a(8'h10); load_b(8'h01);
        ALU_Sel = 3'b000; Bus1_Sel = 2'b01; Bus2_Sel = 2'b11; MAR_Load = 1; tick();
        chk("bus2_11_alu", address, 8'h11);
        Bus2_Sel = 2'b00; Bus1_Sel = 2'b00;
`ifdef DP_BUS_CHECK_EN
        chk("bus_err_set", {7'h0, bus_err}, 8'h01);
        tick(); tick(); tick();
        chk("bus_err_sticky", {7'h0, bus_err}, 8'h01);
`endif

        // Reset mid-instruction, then the first edge is a normal cycle
        Bus2_Sel = 2'b10; from_memory = 8'h99; IR_Load = 1; A_Load = 1;
        #2 Reset = 0;
        #1;
        chk("mid_rst_ir", IR, 8'h00);
        chk("mid_rst_addr", address, 8'h00);
        chk("mid_rst_pc", to_memory, 8'h00);
`ifdef DP_BUS_CHECK_EN
        chk("bus_err_cleared", {7'h0, bus_err}, 8'h00);
`endif
        #1 Reset = 1;
        tick();
        chk("post_rst_ir", IR, 8'h99);
        Bus1_Sel = 2'b01; #1;
        chk("post_rst_a", to_memory, 8'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
